// File: rtl/shifter_share_arbiter_if.sv
// Request, shared-shifter and response signals of shifter_share_arbiter.
// The grant/stall statistics ports exist only when SHARE_ARB_STATS_EN is defined.
interface shifter_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 13,
    parameter int SHW   = $clog2(WIDTH)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*SHW-1:0]   req_shift;
    logic [WIDTH-1:0]      sh_in;
    logic [SHW-1:0]        sh_shift;
    logic                  sh_valid_in;
    logic [WIDTH-1:0]      sh_out;
    logic                  sh_valid_out;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [NREQ*WIDTH-1:0] rsp_data;
    logic                  err_tag;
`ifdef SHARE_ARB_STATS_EN
    logic [NREQ*16-1:0]    grant_count;
    logic [15:0]           stall_count;
`endif

    // slave is the arbiter; master is the requesters plus the shifter
    modport slave (
        input  req_valid, req_data, req_shift, sh_out, sh_valid_out, rsp_ready,
`ifdef SHARE_ARB_STATS_EN
        output grant_count, stall_count,
`endif
        output req_ready, sh_in, sh_shift, sh_valid_in, rsp_valid, rsp_data, err_tag
    );

    modport master (
        output req_valid, req_data, req_shift, sh_out, sh_valid_out, rsp_ready,
`ifdef SHARE_ARB_STATS_EN
        input  grant_count, stall_count,
`endif
        input  req_ready, sh_in, sh_shift, sh_valid_in, rsp_valid, rsp_data, err_tag
    );
endinterface

// File: rtl/shifter_share_arbiter.sv
// Round-robin sharing of one pipelined right-shifter among NREQ requesters, with tag tracking,
// per-requester result FIFOs and credit flow control. SHARE_ARB_STATS_EN adds grant/stall counters.
module shifter_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 13,
    parameter int SHW     = $clog2(WIDTH),
    parameter int LATENCY = 2,
    parameter int RDEPTH  = 4
) (
    input logic clk,
    input logic reset,
    shifter_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RDEPTH + 1);
    localparam int PW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int DW  = $clog2(LATENCY + 1);

    logic [NREQ-1:0]       grant;
    logic                  accept;
    logic [IDW-1:0]        gid;
    logic [IDW-1:0]        ptr;
    logic [CW-1:0]         credit [NREQ];

    logic [WIDTH-1:0]      sh_in_q;
    logic [SHW-1:0]        sh_shift_q;
    logic                  sh_valid_q;
    logic [IDW-1:0]        issue_id;

    logic [LATENCY-1:0]    tag_v;
    logic [IDW-1:0]        tag_id [LATENCY];
    logic [DW-1:0]         drain;
    logic                  head_v;
    logic [IDW-1:0]        head_id;
    logic                  stray;

    logic [WIDTH-1:0]      mem [NREQ][RDEPTH];
    logic [PW-1:0]         rd_ptr [NREQ];
    logic [PW-1:0]         wr_ptr [NREQ];
    logic [CW-1:0]         fcount [NREQ];
    logic [NREQ-1:0]       push;
    logic [NREQ-1:0]       miss;
    logic [NREQ-1:0]       pop;
    logic [NREQ-1:0]       rsp_valid_q;
    logic [NREQ*WIDTH-1:0] rsp_data_q;
    logic                  err_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (int'(p) == RDEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Scan from ptr+1 so the most recent winner has lowest priority next cycle.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        gid    = '0;
        accept = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!accept && !reset && bus.req_valid[idx] && (credit[idx] != '0)) begin
                accept     = 1'b1;
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= IDW'(NREQ - 1);
            sh_in_q    <= '0;
            sh_shift_q <= '0;
            sh_valid_q <= 1'b0;
            issue_id   <= '0;
        end else begin
            sh_valid_q <= accept;
            if (accept) begin
                ptr        <= gid;
                sh_in_q    <= bus.req_data[gid*WIDTH +: WIDTH];
                sh_shift_q <= bus.req_shift[gid*SHW +: SHW];
                issue_id   <= gid;
            end
        end
    end

    // Results issued just before a reset still emerge for LATENCY cycles; drain masks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int s = 0; s < LATENCY; s++) tag_id[s] <= '0;
            drain <= DW'(LATENCY);
        end else begin
            tag_v[0]  <= sh_valid_q;
            tag_id[0] <= issue_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (drain != '0) drain <= drain - DW'(1);
        end
    end

    assign head_v  = tag_v[LATENCY-1];
    assign head_id = tag_id[LATENCY-1];
    assign stray   = bus.sh_valid_out && !head_v && (drain == '0);
    assign pop     = rsp_valid_q & bus.rsp_ready;

    always_comb begin
        push = '0;
        miss = '0;
        for (int i = 0; i < NREQ; i++) begin
            push[i] = bus.sh_valid_out && head_v && (int'(head_id) == i);
            miss[i] = !bus.sh_valid_out && head_v && (int'(head_id) == i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.sh_out;
        end
    end

    // Outputs are registered: the next head is the pushed word only when nothing else remains.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                credit[i] <= CW'(RDEPTH);
                fcount[i] <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                credit[i] <= credit[i] - CW'(grant[i]) + CW'(pop[i]) + CW'(miss[i]);
                fcount[i] <= fcount[i] + CW'(push[i]) - CW'(pop[i]);
                if (push[i]) wr_ptr[i] <= wrap_inc(wr_ptr[i]);
                if (pop[i])  rd_ptr[i] <= wrap_inc(rd_ptr[i]);
                rsp_valid_q[i] <= ((fcount[i] - CW'(pop[i])) != '0) || push[i];
                if ((fcount[i] - CW'(pop[i])) != '0)
                    rsp_data_q[i*WIDTH +: WIDTH] <= mem[i][pop[i] ? wrap_inc(rd_ptr[i]) : rd_ptr[i]];
                else if (push[i])
                    rsp_data_q[i*WIDTH +: WIDTH] <= bus.sh_out;
            end
            if (stray || (head_v && !bus.sh_valid_out)) err_q <= 1'b1;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.sh_in       = sh_in_q;
    assign bus.sh_shift    = sh_shift_q;
    assign bus.sh_valid_in = sh_valid_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.err_tag     = err_q;

`ifdef SHARE_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
    logic [15:0]        stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
            if ((|bus.req_valid) && !accept && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.grant_count = grant_cnt;
    assign bus.stall_count = stall_cnt;
`endif
endmodule

// File: doc/shifter_share_arbiter.md
Name: shifter_share_arbiter

Overview:
- Shares one pipelined right-shifter between NREQ independent requesters in the DTS search datapath.
- Round-robin arbitration grants at most one request per cycle and drives the shifter's input side through registered outputs.
- A tag pipeline aligned to the shifter latency records which requester owns each result, and results are routed into per-requester response FIFOs.
- Per-requester credit counters guarantee a result FIFO can never overflow; the shifter itself has no backpressure.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 13, data width of the shared shifter.
- SHW, $clog2(WIDTH), shift-amount width.
- LATENCY, 2, shifter latency in cycles from sh_valid_in to sh_valid_out; must equal the shifter's stage count.
- RDEPTH, 4, per-requester result FIFO depth, which is also the initial credit count (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_data  in  NREQ*WIDTH  flattened operands; requester i occupies [i*WIDTH +: WIDTH].
- req_shift  in  NREQ*SHW  flattened shift amounts.
- sh_in  out  WIDTH  operand to the shifter (registered).
- sh_shift  out  SHW  shift amount to the shifter (registered).
- sh_valid_in  out  1  issue strobe to the shifter (registered).
- sh_out  in  WIDTH  shifter result.
- sh_valid_out  in  1  shifter result valid.
- rsp_valid  out  NREQ  per-requester result available.
- rsp_ready  in  NREQ  per-requester result pop.
- rsp_data  out  NREQ*WIDTH  flattened results (FIFO heads).
- err_tag  out  1  sticky protocol error flag.

Behaviour:
- Reset:
  - req_ready=0, sh_valid_in=0, sh_in=0, sh_shift=0, rsp_valid=0, rsp_data=0, err_tag=0.
  - All FIFOs emptied, tag pipeline cleared, credits set to RDEPTH.
  - RR pointer set to NREQ-1, so requester 0 has first priority.
  - Reset mid-operation discards all in-flight and buffered results; shifter outputs arriving after reset with no live tag are ignored and do not set err_tag.
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i]>0.
- Arbitration:
  - Combinational scan from ptr+1 modulo NREQ; the first eligible requester gets req_ready[i]=1.
  - A transfer occurs on req_valid[i]&req_ready[i].
  - req_ready may depend on req_valid. Requesters must hold req_valid and data stable until accepted.
- On accept of requester g at cycle t:
  - ptr<=g; credit[g] decrements.
  - At t+1: sh_in/sh_shift carry the selected operands and sh_valid_in=1.
  - When there is no accept, sh_valid_in=0 next cycle; sh_in and sh_shift hold their values.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, id[$clog2(NREQ)-1:0]}, loaded in parallel with sh_valid_in.
  - The head aligns with sh_valid_out.
- Result handling:
  - On sh_valid_out=1 with a valid head tag, sh_out is pushed into FIFO[id].
  - sh_valid_out=1 with an invalid head, or a valid head with sh_valid_out=0, sets err_tag. A missed result is dropped and its credit is restored.
- Latency: accept at t gives rsp_valid[g]=1 at t+LATENCY+2 (t+4 at default).
- FIFOs:
  - Registered outputs; rsp_data shows the head, and rsp_data for an empty FIFO holds its last value.
  - A pop (rsp_valid&rsp_ready) restores one credit.
  - A simultaneous grant and pop on the same requester leaves the credit unchanged.
  - A simultaneous push and pop on the same FIFO is legal, including when the FIFO is full.
  - The credit scheme guarantees no push to a full FIFO. Pointers wrap modulo RDEPTH.
- Throughput: one accept per cycle sustained, given eligible requesters.

Optional Feature:
- Macro SHARE_ARB_STATS_EN.
- When defined:
  - Adds output grant_count, NREQ*16 bits: saturating per-requester accept counters, cleared by reset.
  - Adds output stall_count, 16 bits: counts cycles where some req_valid=1 but no accept occurred; saturating.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- Single request: reset released, req_valid[0]=1 with req_data[0]=13'h1FFF and shift=4 at cycle 0, model shifter LATENCY=2 -> sh_valid_in at cycle 1, rsp_valid[0] at cycle 4 with rsp_data[0]=13'h01FF, and no other rsp_valid.
- Round robin: all four requesters hold req_valid continuously with rsp_ready=all ones -> grant order 0,1,2,3,0,1,... with one accept every cycle and each result routed to its own port.
- Backpressure: rsp_ready[1]=0 while req1 requests continuously -> exactly 4 accepts for req1, then req_ready[1] stays 0; other requesters keep being served. Popping one result lets exactly one more req1 accept.
- Boundary credit: requester with credit 1 issues and pops in the same cycle -> credit remains 1 and the next request is accepted on the following cycle.
- Tag error: force sh_valid_out=1 with the tag pipeline empty -> err_tag=1 next cycle and stays 1 until reset, with no FIFO push.
- Reset mid-flight: assert reset one cycle after 3 accepts -> all rsp_valid=0, credits back to 4, late sh_valid_out ignored with err_tag=0, and the first post-reset accept goes to requester 0.
